// File: rtl/stage_reg_gen_pkg.sv
// ============================================================================
// stage_reg_gen_pkg : core-wide constants shared by the pipeline stage registers
// Revision: 1.0
// ============================================================================
`default_nettype none

package stage_reg_gen_pkg;

  localparam int          CORE_REG_AW    = 5;
  localparam int          CORE_EXC_W     = 5;
  localparam logic [31:0] CORE_PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] CORE_NOP_INSTR = 32'h0000_0000;

  // Exception codes as reported in the CP0 Cause.ExcCode field
  localparam logic [CORE_EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [CORE_EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [CORE_EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [CORE_EXC_W-1:0] EXC_SYS  = 5'd8;
  localparam logic [CORE_EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [CORE_EXC_W-1:0] EXC_OV   = 5'd12;

endpackage

`default_nettype wire

// File: rtl/stage_reg_gen_pipe_field_reg.sv
// ============================================================================
// pipe_field_reg : one pipeline field flop with async reset, clear, hold, load
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_field_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         hold,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // clear beats hold beats load; with none asserted the flop keeps its value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= RST_VAL;
    else if (clr)  q <= CLR_VAL;
    else if (hold) q <= q;
    else if (load) q <= d;
  end

endmodule

`default_nettype wire

// File: rtl/stage_reg_gen.sv
// ============================================================================
// stage_reg_gen : parametrised inter-stage register with stall, flush, operand
//                 refresh while stalled and a saturating stall-cycle counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module stage_reg_gen
  import stage_reg_gen_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                REG_AW    = CORE_REG_AW,
  parameter int                EXC_W     = CORE_EXC_W,
  parameter int                CNT_W     = 8,
  parameter logic [DATA_W-1:0] PC_RESET  = CORE_PC_RESET,
  parameter logic [DATA_W-1:0] NOP_INSTR = CORE_NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] rd1_in,
  input  logic [DATA_W-1:0] rd2_in,
  input  logic [DATA_W-1:0] ext_in,
  input  logic [REG_AW-1:0] rs_in,
  input  logic [REG_AW-1:0] rt_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              bd_in,
  input  logic [EXC_W-1:0]  exc_in,
  input  logic              fwd1_we,
  input  logic              fwd2_we,
  input  logic [DATA_W-1:0] fwd1_data,
  input  logic [DATA_W-1:0] fwd2_data,
  output logic              valid_q,
  output logic [DATA_W-1:0] instr_q,
  output logic [DATA_W-1:0] pc_q,
  output logic [DATA_W-1:0] rd1_q,
  output logic [DATA_W-1:0] rd2_q,
  output logic [DATA_W-1:0] ext_q,
  output logic [REG_AW-1:0] rs_q,
  output logic [REG_AW-1:0] rt_q,
  output logic [REG_AW-1:0] rd_q,
  output logic              bd_q,
  output logic [EXC_W-1:0]  exc_q,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] opnd_in   [2];
  logic [DATA_W-1:0] opnd_fwd  [2];
  logic              opnd_we   [2];
  logic [DATA_W-1:0] opnd_q    [2];
  logic [REG_AW-1:0] idx_in    [3];
  logic [REG_AW-1:0] idx_q     [3];
  logic              epc_hold;

  assign opnd_in[0]  = rd1_in;
  assign opnd_in[1]  = rd2_in;
  assign opnd_fwd[0] = fwd1_data;
  assign opnd_fwd[1] = fwd2_data;
  assign opnd_we[0]  = fwd1_we;
  assign opnd_we[1]  = fwd2_we;
  assign rd1_q       = opnd_q[0];
  assign rd2_q       = opnd_q[1];
  assign idx_in[0]   = rs_in;
  assign idx_in[1]   = rt_in;
  assign idx_in[2]   = rd_in;
  assign rs_q        = idx_q[0];
  assign rt_q        = idx_q[1];
  assign rd_q        = idx_q[2];

  // PC and BD are loaded (not cleared) by a flush so the bubble still carries EPC info
  assign epc_hold = stall && !flush;

  pipe_field_reg #(.W(1), .RST_VAL(1'b0), .CLR_VAL(1'b0)) u_valid (
    .clk(clk), .reset_n(reset_n), .clr(flush), .hold(stall), .load(1'b1),
    .d(valid_in), .q(valid_q));

  pipe_field_reg #(.W(DATA_W), .RST_VAL(NOP_INSTR), .CLR_VAL(NOP_INSTR)) u_instr (
    .clk(clk), .reset_n(reset_n), .clr(flush), .hold(stall), .load(1'b1),
    .d(instr_in), .q(instr_q));

  pipe_field_reg #(.W(DATA_W), .RST_VAL(PC_RESET), .CLR_VAL(PC_RESET)) u_pc (
    .clk(clk), .reset_n(reset_n), .clr(1'b0), .hold(epc_hold), .load(1'b1),
    .d(pc_in), .q(pc_q));

  pipe_field_reg #(.W(1), .RST_VAL(1'b0), .CLR_VAL(1'b0)) u_bd (
    .clk(clk), .reset_n(reset_n), .clr(1'b0), .hold(epc_hold), .load(1'b1),
    .d(bd_in), .q(bd_q));

  pipe_field_reg #(.W(DATA_W), .RST_VAL('0), .CLR_VAL('0)) u_ext (
    .clk(clk), .reset_n(reset_n), .clr(flush), .hold(stall), .load(1'b1),
    .d(ext_in), .q(ext_q));

  pipe_field_reg #(.W(EXC_W), .RST_VAL(EXC_W'(EXC_NONE)), .CLR_VAL(EXC_W'(EXC_NONE))) u_exc (
    .clk(clk), .reset_n(reset_n), .clr(flush), .hold(stall), .load(1'b1),
    .d(exc_in), .q(exc_q));

  generate
    for (genvar i = 0; i < 2; i++) begin : g_operand
      // a stalled operand only moves when the forwarding network refreshes it
      pipe_field_reg #(.W(DATA_W), .RST_VAL('0), .CLR_VAL('0)) u_opnd (
        .clk(clk), .reset_n(reset_n), .clr(flush),
        .hold(stall && !opnd_we[i]), .load(1'b1),
        .d(stall ? opnd_fwd[i] : opnd_in[i]), .q(opnd_q[i]));
    end

    for (genvar j = 0; j < 3; j++) begin : g_reg_idx
      pipe_field_reg #(.W(REG_AW), .RST_VAL('0), .CLR_VAL('0)) u_idx (
        .clk(clk), .reset_n(reset_n), .clr(flush), .hold(stall), .load(1'b1),
        .d(idx_in[j]), .q(idx_q[j]));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              stall_cnt <= '0;
    else if (flush || !stall)  stall_cnt <= '0;
    else if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

`default_nettype wire
